// File: rtl/mc_mem_bridge_pkg.sv
// Shared types for the load/store bridge between the core memory stage and the
// req/gnt/rvalid memory bus.
package mc_mem_bridge_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        MEM_IDLE = 3'd0,
        MEM_REQ  = 3'd1,
        MEM_WAIT = 3'd2,
        MEM_DONE = 3'd3,
        MEM_ERR  = 3'd4
    } mem_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    // Number of significant bits carried by an access of the given size.
    function automatic int unsigned mem_size_bits(input mem_size_e size, input int unsigned xlen);
        int unsigned bits;
        case (size)
            MEM_B:   bits = 8;
            MEM_H:   bits = 16;
            MEM_W:   bits = 32;
            default: bits = xlen;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/mc_mem_bridge_if.sv
// Memory-side bus of the bridge: request/grant handshake plus read-data return.
interface mc_mem_bridge_if #(
    parameter int XLEN = 32
);
    localparam int BE_W = XLEN / 8;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mc_mem_bridge_mem_lane_align.sv
// Purely combinational lane steering: byte enables, store replication, load
// extraction/extension and alignment checking for one access.
module mc_mem_bridge_mem_lane_align
    import mc_mem_bridge_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W),
    localparam int SH_W  = OFF_W + 3
) (
    input  mem_size_e        size_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [BE_W-1:0]  be_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  rdata_o,
    output logic             misaligned_o,
    output logic             illegal_o
);

    logic [SH_W-1:0] lane_sh;
    logic [SH_W-1:0] keep_sh;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] left;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        be_o         = '0;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_B: begin
                be_o    = BE_W'(1) << off_i;
                wdata_o = {BE_W{wdata_i[7:0]}};
            end
            MEM_H: begin
                be_o         = BE_W'(3) << off_i;
                wdata_o      = {(BE_W / 2){wdata_i[15:0]}};
                misaligned_o = off_i[0];
            end
            MEM_W: begin
                be_o         = BE_W'(15) << off_i;
                wdata_o      = {(BE_W / 4){wdata_i[31:0]}};
                misaligned_o = |off_i[1:0];
            end
            default: begin
                be_o         = '1;
                wdata_o      = wdata_i;
                misaligned_o = |off_i;
            end
        endcase
    end

    assign illegal_o = (size_i == MEM_D) && (XLEN != 64);

    // Move the addressed lane to bit 0, park its top bit at the MSB, then shift
    // back down logically or arithmetically to zero- or sign-extend.
    always_comb begin
        lane_sh = {off_i, 3'b000};
        shifted = rdata_i >> lane_sh;
        keep_sh = SH_W'(XLEN - mem_size_bits(size_i, XLEN));
        left    = shifted << keep_sh;
        rdata_o = unsigned_i ? (left >> keep_sh) : XLEN'($signed(left) >>> keep_sh);
    end

endmodule

// File: rtl/mc_mem_bridge.sv
// Load/store bridge: turns a core memory request into a stalled req/gnt/rvalid
// bus transaction with sub-word lanes, misalignment trapping and a bus timeout.
module mc_mem_bridge
    import mc_mem_bridge_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    input  logic [1:0]      core_size_i,
    input  logic            core_unsigned_i,
    output logic            core_stall_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_err_o,
    mc_mem_bridge_if.master bus
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    mem_size_e       size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    mem_size_e        al_size;
    logic [OFF_W-1:0] al_off;
    logic [BE_W-1:0]  al_be;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_rdata;
    logic             al_misaligned;
    logic             al_illegal;
    logic             in_req;
    logic             cnt_expired;

    // In IDLE the checker looks at the live request; afterwards at the latched one.
    assign al_size = (state_q == MEM_IDLE) ? mem_size_e'(core_size_i) : size_q;
    assign al_off  = (state_q == MEM_IDLE) ? core_addr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];

    mc_mem_bridge_mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .size_i       (al_size),
        .off_i        (al_off),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .rdata_i      (bus.rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    // A grant on the last budget cycle still counts, so WAIT tests with >=.
    assign cnt_expired = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        case (state_q)
            MEM_IDLE: begin
                if (core_req_i) begin
                    we_d    = core_we_i;
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    size_d  = mem_size_e'(core_size_i);
                    uns_d   = core_unsigned_i;
                    if (al_misaligned || al_illegal) begin
                        state_d = MEM_ERR;
                    end else begin
                        state_d = MEM_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            MEM_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.gnt) begin
                    state_d = we_q ? MEM_DONE : MEM_WAIT;
                end else if (cnt_expired) begin
                    state_d = MEM_ERR;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.rvalid) begin
                    rdata_d = al_rdata;
                    state_d = MEM_DONE;
                end else if (cnt_expired) begin
                    state_d = MEM_ERR;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            MEM_ERR:  state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= MEM_B;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus fields are forced to zero outside REQ so the bus is quiet when idle.
    assign in_req    = (state_q == MEM_REQ);
    assign bus.req   = in_req;
    assign bus.we    = in_req & we_q;
    assign bus.addr  = in_req ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.be    = in_req ? al_be : '0;
    assign bus.wdata = in_req ? al_wdata : '0;

    assign core_stall_o = ((state_q == MEM_IDLE) && core_req_i) ||
                          (state_q == MEM_REQ) || (state_q == MEM_WAIT);
    assign core_err_o   = (state_q == MEM_ERR);
    assign core_rdata_o = rdata_q;

endmodule

// File: tb/tb_mc_mem_bridge.sv
// Directed scoreboard bench for mc_mem_bridge: 32-bit default, 32-bit with a
// short timeout, and a 64-bit instance.
module tb_mc_mem_bridge;
    import mc_mem_bridge_pkg::*;

    typedef struct {
        string       tag;
        logic        err;
        logic [63:0] rdata;
        int          stall;
        int          nreq;
        logic        we;
        logic [63:0] addr;
        logic [63:0] be;
        logic [63:0] wdata;
    } exp_t;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [2:0]  req_v  = '0;
    logic        core_we = 1'b0;
    logic [63:0] core_addr = '0;
    logic [63:0] core_wdata = '0;
    logic [1:0]  core_size = '0;
    logic        core_uns = 1'b0;
    logic [2:0]  gnt_v = '0;
    logic [2:0]  rv_v  = '0;
    logic [63:0] bus_rd = '0;

    logic        stall0, stall1, stall2;
    logic        err0, err1, err2;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    mc_mem_bridge_if #(.XLEN(32)) bif0 ();
    mc_mem_bridge_if #(.XLEN(32)) bif1 ();
    mc_mem_bridge_if #(.XLEN(64)) bif2 ();

    assign bif0.gnt = gnt_v[0]; assign bif0.rvalid = rv_v[0]; assign bif0.rdata = bus_rd[31:0];
    assign bif1.gnt = gnt_v[1]; assign bif1.rvalid = rv_v[1]; assign bif1.rdata = bus_rd[31:0];
    assign bif2.gnt = gnt_v[2]; assign bif2.rvalid = rv_v[2]; assign bif2.rdata = bus_rd;

    mc_mem_bridge #(.XLEN(32), .TIMEOUT_CYCLES(16)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .core_req_i(req_v[0]), .core_we_i(core_we),
        .core_addr_i(core_addr[31:0]), .core_wdata_i(core_wdata[31:0]), .core_size_i(core_size),
        .core_unsigned_i(core_uns), .core_stall_o(stall0), .core_rdata_o(rd0),
        .core_err_o(err0), .bus(bif0)
    );

    mc_mem_bridge #(.XLEN(32), .TIMEOUT_CYCLES(4)) u_dut_to (
        .clk_i(clk_i), .rstn_i(rstn_i), .core_req_i(req_v[1]), .core_we_i(core_we),
        .core_addr_i(core_addr[31:0]), .core_wdata_i(core_wdata[31:0]), .core_size_i(core_size),
        .core_unsigned_i(core_uns), .core_stall_o(stall1), .core_rdata_o(rd1),
        .core_err_o(err1), .bus(bif1)
    );

    mc_mem_bridge #(.XLEN(64), .TIMEOUT_CYCLES(16)) u_dut64 (
        .clk_i(clk_i), .rstn_i(rstn_i), .core_req_i(req_v[2]), .core_we_i(core_we),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_size_i(core_size),
        .core_unsigned_i(core_uns), .core_stall_o(stall2), .core_rdata_o(rd2),
        .core_err_o(err2), .bus(bif2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic err, input logic [63:0] rdata,
                                input int stall, input int nreq, input logic we,
                                input logic [63:0] addr, input logic [63:0] be,
                                input logic [63:0] wdata);
        exp_t e;
        e.tag = tag; e.err = err; e.rdata = rdata; e.stall = stall; e.nreq = nreq;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        return e;
    endfunction

    task automatic sample(input int sel, output logic st, output logic rq, output logic wem,
                          output logic er, output logic [63:0] ad, output logic [63:0] bem,
                          output logic [63:0] wd, output logic [63:0] rd);
        case (sel)
            0: begin
                st = stall0; rq = bif0.req; wem = bif0.we; er = err0;
                ad = 64'(bif0.addr); bem = 64'(bif0.be); wd = 64'(bif0.wdata); rd = 64'(rd0);
            end
            1: begin
                st = stall1; rq = bif1.req; wem = bif1.we; er = err1;
                ad = 64'(bif1.addr); bem = 64'(bif1.be); wd = 64'(bif1.wdata); rd = 64'(rd1);
            end
            default: begin
                st = stall2; rq = bif2.req; wem = bif2.we; er = err2;
                ad = bif2.addr; bem = 64'(bif2.be); wd = bif2.wdata; rd = rd2;
            end
        endcase
    endtask

    // Drives one access on instance sel and plays the memory: grant on REQ cycle
    // gnt_after+1, rvalid on WAIT cycle rv_after+1. Called just after a posedge.
    task automatic run(input int sel, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                       input int gnt_after, input int rv_after, input logic [63:0] rdata,
                       input logic junk_rv);
        logic st, rq, wem, er;
        logic [63:0] ad, bem, wd, rd;
        int   stall_n = 0;
        int   nreq = 0;
        int   nwait = 0;
        logic granted = 1'b0;
        logic done = 1'b0;
        exp_t e;
        core_we = we; core_addr = addr; core_wdata = wdata; core_size = size; core_uns = uns;
        req_v[sel] = 1'b1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk_i);
            sample(sel, st, rq, wem, er, ad, bem, wd, rd);
            if (sb.size() == 0) begin
                check("sb_empty", 64'(sb.size()), 64'd1);
                done = 1'b1;
            end else if (st) begin
                stall_n++;
                if (rq) begin
                    nreq++;
                    check({sb[0].tag, "_addr"}, ad, sb[0].addr);
                    check({sb[0].tag, "_be"}, bem, sb[0].be);
                    check({sb[0].tag, "_wdata"}, wd, sb[0].wdata);
                    check({sb[0].tag, "_we"}, 64'(wem), 64'(sb[0].we));
                    if (nreq == gnt_after + 1) begin
                        gnt_v[sel] = 1'b1;
                        granted = !we;
                        if (junk_rv) begin
                            rv_v[sel] = 1'b1;
                            bus_rd = ~rdata;
                        end
                    end
                end else if (granted) begin
                    nwait++;
                    if (nwait == rv_after + 1) begin
                        rv_v[sel] = 1'b1;
                        bus_rd = rdata;
                    end
                end
            end else begin
                e = sb.pop_front();
                check({e.tag, "_err"}, 64'(er), 64'(e.err));
                check({e.tag, "_rdata"}, rd, e.rdata);
                check({e.tag, "_stall_cycles"}, 64'(stall_n), 64'(e.stall));
                check({e.tag, "_req_cycles"}, 64'(nreq), 64'(e.nreq));
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
            gnt_v[sel] = 1'b0;
            rv_v[sel]  = 1'b0;
            if (done) req_v[sel] = 1'b0;
        end
        if (!done) begin
            check("access_cycle_budget", 64'd0, 64'd1);
            req_v[sel] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 64'(stall0), 64'd0);
        check("rst_bus_req", 64'(bif0.req), 64'd0);
        check("rst_err", 64'(err0), 64'd0);
        check("rst_rdata", 64'(rd0), 64'd0);
        check("rst_be", 64'(bif0.be), 64'd0);
        check("rst_rdata64", rd2, 64'd0);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        sb.push_back(mk("lw", 1'b0, 64'hDEADBEEF, 6, 2, 1'b0, 64'h1000, 64'hF, 64'h0));
        run(0, 1'b0, 64'h1000, 64'h0, 2'd2, 1'b0, 1, 2, 64'hDEADBEEF, 1'b0);

        sb.push_back(mk("lb", 1'b0, 64'hFFFFFF80, 3, 1, 1'b0, 64'h1000, 64'h8, 64'h0));
        run(0, 1'b0, 64'h1003, 64'h0, 2'd0, 1'b0, 0, 0, 64'h80123456, 1'b1);

        sb.push_back(mk("lbu", 1'b0, 64'h00000080, 3, 1, 1'b0, 64'h1000, 64'h8, 64'h0));
        run(0, 1'b0, 64'h1003, 64'h0, 2'd0, 1'b1, 0, 0, 64'h80123456, 1'b0);

        sb.push_back(mk("sh", 1'b0, 64'h00000080, 2, 1, 1'b1, 64'h2000, 64'hC, 64'hBEEFBEEF));
        run(0, 1'b1, 64'h2002, 64'h1234BEEF, 2'd1, 1'b0, 0, 0, 64'h0, 1'b0);

        sb.push_back(mk("sb", 1'b0, 64'h00000080, 2, 1, 1'b1, 64'h3000, 64'h2, 64'hA5A5A5A5));
        run(0, 1'b1, 64'h3001, 64'h000000A5, 2'd0, 1'b0, 0, 0, 64'h0, 1'b0);

        sb.push_back(mk("lh", 1'b0, 64'hFFFF8001, 4, 1, 1'b0, 64'h1000, 64'hC, 64'h0));
        run(0, 1'b0, 64'h1002, 64'h0, 2'd1, 1'b0, 0, 1, 64'h80011234, 1'b0);

        sb.push_back(mk("lw_mis", 1'b1, 64'hFFFF8001, 1, 0, 1'b0, 64'h0, 64'h0, 64'h0));
        run(0, 1'b0, 64'h1002, 64'h0, 2'd2, 1'b0, 0, 0, 64'h0, 1'b0);
        @(negedge clk_i);
        check("err_one_cycle", 64'(err0), 64'd0);
        check("err_idle_stall", 64'(stall0), 64'd0);
        @(posedge clk_i);
        #1;

        sb.push_back(mk("ld_on_32", 1'b1, 64'hFFFF8001, 1, 0, 1'b0, 64'h0, 64'h0, 64'h0));
        run(0, 1'b0, 64'h1000, 64'h0, 2'd3, 1'b0, 0, 0, 64'h0, 1'b0);

        sb.push_back(mk("lhu_mis", 1'b1, 64'hFFFF8001, 1, 0, 1'b0, 64'h0, 64'h0, 64'h0));
        run(0, 1'b0, 64'h1001, 64'h0, 2'd1, 1'b1, 0, 0, 64'h0, 1'b0);

        sb.push_back(mk("timeout", 1'b1, 64'h0, 5, 4, 1'b0, 64'h4000, 64'hF, 64'h0));
        run(1, 1'b0, 64'h4000, 64'h0, 2'd2, 1'b0, 1000, 0, 64'h0, 1'b0);
        @(negedge clk_i);
        check("timeout_err_pulse", 64'(err1), 64'd0);
        check("timeout_idle_req", 64'(bif1.req), 64'd0);
        @(posedge clk_i);
        #1;

        sb.push_back(mk("ld64", 1'b0, 64'h0123456789ABCDEF, 3, 1, 1'b0, 64'h8, 64'hFF, 64'h0));
        run(2, 1'b0, 64'h8, 64'h0, 2'd3, 1'b0, 0, 0, 64'h0123456789ABCDEF, 1'b0);

        sb.push_back(mk("lw64_hi", 1'b0, 64'hFFFFFFFF80000001, 3, 1, 1'b0, 64'h8, 64'hF0, 64'h0));
        run(2, 1'b0, 64'hC, 64'h0, 2'd2, 1'b0, 0, 0, 64'h80000001_12345678, 1'b0);

        // Reset in the middle of WAIT, then a stray rvalid.
        core_we = 1'b0; core_addr = 64'h5000; core_size = 2'd2; core_uns = 1'b0;
        req_v[0] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        gnt_v[0] = 1'b1;
        @(posedge clk_i);
        #1;
        gnt_v[0] = 1'b0;
        #2;
        check("rst_pre_wait_stall", 64'(stall0), 64'd1);
        rstn_i = 1'b0;
        req_v[0] = 1'b0;
        #1;
        check("async_rst_stall", 64'(stall0), 64'd0);
        check("async_rst_bus_req", 64'(bif0.req), 64'd0);
        check("async_rst_err", 64'(err0), 64'd0);
        check("async_rst_rdata", 64'(rd0), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            rv_v[0] = 1'b1;
            bus_rd = 64'hCAFEF00D;
            @(negedge clk_i);
            check("stray_rv_stall", 64'(stall0), 64'd0);
            check("stray_rv_rdata", 64'(rd0), 64'd0);
            check("stray_rv_err", 64'(err0), 64'd0);
            check("stray_rv_bus_req", 64'(bif0.req), 64'd0);
        end
        rv_v[0] = 1'b0;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
